// File: rtl/mips32_pkg.sv
// mips32_pkg: shared widths, opcode constants and arbiter state encoding for the MIPS32 memory arbiter.
package mips32_pkg;
  localparam int AW_DEF = 10;
  localparam int DW_DEF = 32;
  localparam logic [5:0] OP_HLT = 6'b111111;
  localparam logic [31:0] ABORT_INSTR = {OP_HLT, 26'd0};
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;
endpackage

// File: rtl/mips32_arb_wdog.sv
// mips32_arb_wdog: counts BUSY cycles and flags the TIMEOUT-th one so a hung access can be aborted.
module mips32_arb_wdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk1,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + CW'(1);
  end
  assign expire_o = en_i & (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mips32_mem_arbiter.sv
// mips32_mem_arbiter: shares one memory between fetch and data ports, data first, with a watchdog abort.
// Define MIPS32_ARB_FAIR_EN to force a fetch grant after STARVE_MAX back-to-back data grants.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int TIMEOUT    = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_done,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          bus_err
);
  arb_state_e state_q, state_d;
  logic busy, fin, expire, force_if;
  logic [DW-1:0] rd;
  logic mem_req_q, mem_we_q, if_done_q, dm_done_q, bus_err_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;

  mips32_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk1    (clk1),
    .rst_n   (rst_n),
    .clr_i   (if_gnt | dm_gnt),
    .en_i    (busy),
    .expire_o(expire)
  );

  always_comb begin
    busy    = state_q != IDLE;
    if_gnt  = ~busy & if_req & (~dm_req | force_if);
    dm_gnt  = ~busy & dm_req & ~if_gnt;
    // a ready on the watchdog's last cycle still counts as a normal completion
    fin     = busy & (mem_ready | expire);
    rd      = mem_ready ? mem_rdata : DW'(ABORT_INSTR);
    state_d = if_gnt ? BUSY_I : dm_gnt ? BUSY_D : fin ? IDLE : state_q;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      if_done_q <= fin & (state_q == BUSY_I);
      dm_done_q <= fin & (state_q == BUSY_D);
      if (if_gnt | dm_gnt) begin
        mem_req_q  <= 1'b1;
        mem_we_q   <= dm_gnt & dm_we;
        mem_addr_q <= dm_gnt ? dm_addr : if_addr;
        if (dm_gnt) mem_wdata_q <= dm_wdata;
      end else if (fin) mem_req_q <= 1'b0;
      if (fin & (state_q == BUSY_I)) if_rdata_q <= rd;
      if (fin & (state_q == BUSY_D) & ~mem_we_q) dm_rdata_q <= rd;
      if (fin & ~mem_ready) bus_err_q <= 1'b1;
    end
  end

`ifdef MIPS32_ARB_FAIR_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;
  assign force_if = starve_q == SW'(STARVE_MAX);
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else if (!if_req | if_gnt) starve_q <= '0;
    else if (dm_gnt) starve_q <= starve_q + SW'(1);
  end
`else
  assign force_if = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// tb_mips32_mem_arbiter: directed scenarios plus random traffic against a cycle-level reference model.
module tb_mips32_mem_arbiter;
  localparam int AW = 10, DW = 32, TIMEOUT = 16, STARVE_MAX = 4;
  localparam logic [31:0] HLT_WORD = 32'hFC000000;
  localparam logic [31:0] M5 = 32'h2801000A, M20 = 32'h8C0A1234;

  logic clk1 = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0, mem_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0, mem_rdata = '0;
  logic if_gnt, if_done, dm_gnt, dm_done, mem_req, mem_we, bus_err;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk1(clk1), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .bus_err(bus_err)
  );

  always #5 clk1 = ~clk1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drv();
    @(posedge clk1);
    #1;
  endtask

  // memory responder: lat = ready after that many BUSY cycles, 0 = random 1..5, 99 = never
  logic [DW-1:0] mem [1024];
  int lat = 1, lat_cur = 0, bcnt = 0;
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[5] = M5;
    mem[20] = M20;
    forever begin
      @(posedge clk1);
      #1;
      if (mem_req) begin
        bcnt++;
        if (bcnt == 1) lat_cur = (lat == 0) ? $urandom_range(1, 5) : lat;
      end else bcnt = 0;
      mem_ready = mem_req ? (bcnt == lat_cur) : ($urandom_range(0, 3) == 0);
      mem_rdata = mem_req ? mem[mem_addr] : $urandom;
    end
  end

  logic ifg_s = 1'b0, dmg_s = 1'b0;
  always @(negedge clk1) begin
    ifg_s = if_gnt;
    dmg_s = dm_gnt;
  end

  // reference model: one access in flight, tracked as owner + age in cycles
  bit m_busy, m_own_d, m_we, m_ifd, m_dmd, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_ifr, m_dmr;
  int m_age, m_starve;

  function automatic void m_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_ifd = 0; m_dmd = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0; m_age = 0; m_starve = 0;
  endfunction

  initial m_reset();

  always @(negedge clk1) begin
    bit eg_if, eg_dm, fin, force_if;
    if (!rst_n) m_reset();
`ifdef MIPS32_ARB_FAIR_EN
    force_if = m_starve >= STARVE_MAX;
`else
    force_if = 0;
`endif
    eg_if = !m_busy && if_req && (!dm_req || force_if);
    eg_dm = !m_busy && dm_req && !eg_if;
    chk("if_gnt", if_gnt, eg_if);
    chk("dm_gnt", dm_gnt, eg_dm);
    chk("if_done", if_done, m_ifd);
    chk("dm_done", dm_done, m_dmd);
    chk("if_rdata", if_rdata, m_ifr);
    chk("dm_rdata", dm_rdata, m_dmr);
    chk("mem_req", mem_req, m_busy);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("bus_err", bus_err, m_err);
    if (rst_n) begin
      fin = m_busy && (mem_ready || m_age == TIMEOUT);
      m_ifd = fin && !m_own_d;
      m_dmd = fin && m_own_d;
      if (fin) begin
        if (!m_own_d) m_ifr = mem_ready ? mem_rdata : HLT_WORD;
        else if (!m_we) m_dmr = mem_ready ? mem_rdata : HLT_WORD;
        if (!mem_ready) m_err = 1;
        m_busy = 0;
      end else if (m_busy) m_age++;
      if (eg_if || eg_dm) begin
        m_busy = 1;
        m_age = 1;
        m_own_d = eg_dm;
        m_we = eg_dm && dm_we;
        m_addr = eg_dm ? dm_addr : if_addr;
        if (eg_dm) m_wdata = dm_wdata;
      end
      m_starve = (!if_req || eg_if) ? 0 : m_starve + (eg_dm ? 1 : 0);
    end
  end

  initial begin
    int pulses, found, cnt, ndm, got;
    @(negedge clk1);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    drv();
    rst_n = 1'b1;
    drv();

    // fetch read, ready on the second BUSY cycle
    lat = 2; if_req = 1; if_addr = 5;
    @(negedge clk1); chk("t1_if_gnt", if_gnt, 1);
    drv(); if_req = 0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk1);
      if (mem_req) chk("t1_mem_we", mem_we, 0);
      if (if_done) begin pulses++; chk("t1_if_rdata", if_rdata, M5); end
    end
    chk("t1_done_count", pulses, 1);

    // collision: data first, fetch granted in the IDLE cycle carrying dm_done
    drv(); if_req = 1; if_addr = 9; dm_req = 1; dm_we = 0; dm_addr = 20;
    @(negedge clk1); chk("t2_dm_gnt", dm_gnt, 1); chk("t2_if_gnt_blocked", if_gnt, 0);
    drv(); dm_req = 0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      if (dm_done) begin
        found = 1;
        chk("t2_if_gnt_after_done", if_gnt, 1);
        chk("t2_dm_rdata", dm_rdata, M20);
        break;
      end
    end
    chk("t2_dm_done_seen", found, 1);
    drv(); if_req = 0;
    repeat (6) drv();

    // store
    dm_req = 1; dm_we = 1; dm_addr = 7; dm_wdata = 32'h55;
    @(negedge clk1); chk("t3_dm_gnt", dm_gnt, 1);
    drv(); dm_req = 0; dm_we = 0;
    @(negedge clk1);
    chk("t3_mem_req", mem_req, 1); chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_wdata", mem_wdata, 32'h55); chk("t3_mem_addr", mem_addr, 7);
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      if (dm_done) begin found = 1; break; end
    end
    chk("t3_dm_done_seen", found, 1);
    chk("t3_dm_rdata_kept", dm_rdata, M20);

    // watchdog abort of a fetch
    drv(); lat = 99; if_req = 1; if_addr = 3;
    @(negedge clk1); chk("t4_if_gnt", if_gnt, 1);
    drv(); if_req = 0;
    cnt = 0; found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (mem_req) cnt++;
      if (if_done) begin found = 1; break; end
    end
    chk("t4_busy_cycles", cnt, TIMEOUT);
    chk("t4_if_done_seen", found, 1);
    chk("t4_if_rdata_hlt", if_rdata, HLT_WORD);
    chk("t4_bus_err", bus_err, 1);
    repeat (5) @(negedge clk1);
    chk("t4_bus_err_sticky", bus_err, 1);
    drv(); rst_n = 0;
    @(negedge clk1); chk("t4_bus_err_rst", bus_err, 0);
    drv(); rst_n = 1;

    // reset in the middle of a data access
    drv(); dm_req = 1; dm_we = 0; dm_addr = 30;
    @(negedge clk1); chk("t5_dm_gnt", dm_gnt, 1);
    drv(); dm_req = 0;
    drv();
    @(negedge clk1); chk("t5_mem_req_busy", mem_req, 1);
    #2 rst_n = 0;
    #1 chk("t5_mem_req_rst", mem_req, 0);
    drv(); drv(); rst_n = 1; lat = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (dm_done) cnt++;
    end
    chk("t5_no_done", cnt, 0);
    drv(); if_req = 1; if_addr = 1;
    @(negedge clk1); chk("t5_idle_if_gnt", if_gnt, 1);
    drv(); if_req = 0;
    repeat (4) drv();

    // random traffic with random latency, then with a hung memory
    for (int c = 0; c < 3200; c++) begin
      if (c == 3000) lat = 99;
      else if (c == 0) lat = 0;
      if (!if_req || ifg_s) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = $urandom;
      end
      if (!dm_req || dmg_s) begin
        dm_req = $urandom_range(0, 2) != 0;
        dm_we = $urandom_range(0, 1);
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      drv();
    end
    if_req = 0; dm_req = 0; rst_n = 0;
    drv(); drv(); rst_n = 1; lat = 1;
    drv();

    // starvation: data held high alongside a waiting fetch
    dm_req = 1; dm_we = 0; dm_addr = 11; if_req = 1; if_addr = 2;
    ndm = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (if_gnt) begin got = 1; break; end
      if (dm_gnt) ndm++;
    end
`ifdef MIPS32_ARB_FAIR_EN
    chk("t6_if_gnt_seen", got, 1);
    chk("t6_dm_grants", ndm, STARVE_MAX);
`else
    chk("t6_if_never", got, 0);
    chk("t6_dm_grants_many", ndm >= 10, 1);
`endif
    drv(); dm_req = 0;
    if (got) if_req = 0;
    else begin
      for (int i = 0; i < 10; i++) begin
        @(negedge clk1);
        if (if_gnt) break;
      end
      drv(); if_req = 0;
    end
    repeat (6) drv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
